mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port controller that shares the single-port, level-sensitive `memory` block between the processor's instruction-fetch port and its load/store port. It arbitrates between the two ports and drives `memory` from registered signals only. It performs read-modify-write for sub-word stores, because `memory` only supports full 32-bit writes. The block sits between the core's fetch/LSU logic and `memory`.

## Interface
- `FIXED_PRIORITY`, default 0: 0 = round-robin on contention; 1 = data port always wins.
- `clk` input 1: sole clock; every flop is rising-edge.
- `reset` input 1: synchronous, active-high.
- `i_req` input 1: instruction fetch request.
- `i_addr` input 32: fetch byte address; bits [1:0] ignored.
- `i_rdata` output 32: fetched word; valid while `i_ack`=1.
- `i_ack` output 1: one-cycle completion pulse.
- `d_req` input 1: data request.
- `d_we` input 1: 1 = store, 0 = load.
- `d_be` input 4: byte enables for a store; bit n selects bits [8n+7:8n].
- `d_addr` input 32: data byte address; bits [1:0] ignored.
- `d_wdata` input 32: store data, already lane-aligned.
- `d_rdata` output 32: loaded word; valid while `d_ack`=1.
- `d_ack` output 1: one-cycle completion pulse.
- `mem_address` output 32: to `memory.address`; bits [1:0] always 0.
- `mem_data_in` output 32: to `memory.data_in`.
- `mem_we` output 1: to `memory.we`.
- `mem_data_out` input 32: from `memory.data_out`, combinational read.

## Operation
- FSM states: IDLE, ACCESS, MERGE, DONE. Reset state is IDLE.
- **IDLE:** sample `i_req`/`d_req`.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high:
    - `FIXED_PRIORITY`=1: grant data.
    - Otherwise grant the port not granted last. `last_grant` resets to "data", so the instruction port wins the first contention.
  - On grant: latch port id, word address, `d_we`, `d_be`, `d_wdata`; go to ACCESS.
- **ACCESS:** drive `mem_address` with the latched address.
  - Fetch, load, or store with `d_be`=0000: `mem_we`=0; capture `mem_data_out` into the granted port's rdata register; go to DONE. A store with be=0000 is a no-op store; `d_rdata` is don't-care.
  - Store with `d_be`=1111: `mem_we`=1, `mem_data_in`=`d_wdata`; go to DONE.
  - Store with any other `d_be`: `mem_we`=0; capture the old word; go to MERGE.
- **MERGE:** `mem_we`=1. `mem_data_in` = per byte, `d_wdata` where be=1, else the captured old word. Address unchanged. Go to DONE.
- **DONE:**
  - Assert the granted port's ack for exactly this cycle.
  - `mem_we`=0; `mem_address` and `mem_data_in` held from the previous cycle, so the level-sensitive memory cannot write a neighbour word.
  - Update `last_grant`; go to IDLE.
- `mem_we`, `mem_address`, `mem_data_in`, both ack signals and both rdata signals are flop outputs. No combinational path exists from any input to any `mem_*` output.
- Requesters hold `req` and the request fields stable until they see ack, and drop or replace `req` on the clock edge ending the ack cycle. A `req` still high in the following IDLE is a new request.
- Reset at any point:
  - FSM to IDLE; the in-flight transaction is dropped. A partial RMW may leave the memory word unwritten but never half-merged.
  - Outputs reset: `i_ack`, `d_ack`, `mem_we` = 0; `i_rdata`, `d_rdata`, `mem_address`, `mem_data_in` = 0; `last_grant` = data.

## Timing
- Cycle 0 = IDLE cycle in which `req` is sampled high.
- Fetch, load, full-word store, be=0000 store: ACCESS in cycle 1, ack and rdata in cycle 2; 3 cycles IDLE-to-IDLE.
- Partial store: read in cycle 1, write in cycle 2, ack in cycle 3.
- Back-to-back: the next grant is sampled in cycle 3 (or 4 for a partial store). No pipelining; at most one transaction in flight.
- `mem_we` is high for exactly one cycle per store. `mem_address` is constant from ACCESS through DONE.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum (IDLE, ACCESS, MERGE, DONE);
  - port-id constants (`PORT_I`, `PORT_D`);
  - `BE_NONE`=4'b0000 and `BE_FULL`=4'b1111.
- One combinational sub-module, `mem_byte_merge`: inputs old word, new word, be; output merged word. It is used in MERGE and unit-tested separately.

## Test plan
- **Single fetch:** `i_req`, `i_addr`=0x10 with memory word 4 = 0xDEADBEEF → `i_ack` and `i_rdata`=0xDEADBEEF in cycle 2; `mem_we` never high.
- **Full store then load:** 0xCAFEF00D, be=1111 to 0x20 → one `mem_we` pulse in cycle 1, `d_ack` in cycle 2. Load from 0x20 then returns 0xCAFEF00D.
- **Partial store:** word 0x11223344 at 0x30; store 0x0000AA00, be=0010 → `mem_we` only in cycle 2, `d_ack` in cycle 3; the word reads back 0x1122AA44.
- **Contention:** `i_req` and `d_req` held continuously with `FIXED_PRIORITY`=0 → grant order I, D, I, D. With `FIXED_PRIORITY`=1 → D repeatedly, I only when `d_req` is low.
- **Reset mid-RMW:** assert `reset` in the ACCESS cycle of a be=0001 store → next cycle is IDLE, no `mem_we` pulse, no ack, memory word unchanged.
- **Aliasing guard:** store to 0x40, then immediately issue a load to 0x44 → word 0x44 unchanged; `mem_address` equals 0x40 throughout ACCESS and DONE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// FSM encoding, port identifiers and byte-enable patterns.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef logic port_t;

  localparam port_t PORT_I = 1'b0;
  localparam port_t PORT_D = 1'b1;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_FULL = 4'b1111;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/mem_byte_merge.sv
// Byte-lane merge of new store data over an old word; purely combinational.
// Lanes with be=1 take new_word, the rest keep old_word.
module mem_byte_merge
  import mem_arb_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged_word
);

  always_comb begin
    merged_word = old_word;
    for (int n = 0; n < BYTES_PER_WORD; n++) begin
      if (be[n]) begin
        merged_word[8*n +: 8] = new_word[8*n +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port level-sensitive memory between fetch and load/store ports, one
// transaction in flight (3 cycles, 4 for a sub-word RMW store); requesters hold req until ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,

  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  input  logic [31:0] mem_data_out
);

  state_e      state_q, state_d;
  port_t       port_q, port_d;
  port_t       last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;

  logic        any_req;
  port_t       grant_port;
  logic        grant_full_store;
  logic        is_partial;
  logic        is_full_store;
  logic [31:0] merged_word;

  // Word addressing only; the low address bits carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign any_req    = i_req | d_req;
  assign grant_port = (d_req && (!i_req || (FIXED_PRIORITY != 0) || (last_grant_q == PORT_I)))
                      ? PORT_D : PORT_I;
  assign grant_full_store = (grant_port == PORT_D) && d_we && (d_be == BE_FULL);

  assign is_full_store = we_q && (be_q == BE_FULL);
  assign is_partial    = we_q && (be_q != BE_NONE) && (be_q != BE_FULL);

  mem_byte_merge u_merge (
    .old_word    (mem_data_out),
    .new_word    (wdata_q),
    .be          (be_q),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      port_q        <= PORT_I;
      last_grant_q  <= PORT_D;
      we_q          <= 1'b0;
      be_q          <= BE_NONE;
      wdata_q       <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      port_q        <= port_d;
      last_grant_q  <= last_grant_d;
      we_q          <= we_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = is_partial ? MERGE : DONE;
      MERGE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    port_d        = port_q;
    last_grant_d  = last_grant_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_ack_d       = 1'b0;
    d_ack_d       = 1'b0;
    mem_we_d      = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          port_d  = grant_port;
          we_d    = (grant_port == PORT_D) ? d_we : 1'b0;
          be_d    = (grant_port == PORT_D) ? d_be : BE_NONE;
          wdata_d = d_wdata;
          mem_address_d = (grant_port == PORT_D) ? {d_addr[31:2], 2'b00}
                                                 : {i_addr[31:2], 2'b00};
          // A full-word store writes during ACCESS, so its data must be staged now.
          if (grant_full_store) begin
            mem_we_d      = 1'b1;
            mem_data_in_d = d_wdata;
          end
        end
      end
      ACCESS: begin
        if (is_partial) begin
          mem_we_d      = 1'b1;
          mem_data_in_d = merged_word;
        end else begin
          if (!is_full_store) begin
            if (port_q == PORT_I) i_rdata_d = mem_data_out;
            else                  d_rdata_d = mem_data_out;
          end
          if (port_q == PORT_I) i_ack_d = 1'b1;
          else                  d_ack_d = 1'b1;
        end
      end
      MERGE: begin
        if (port_q == PORT_I) i_ack_d = 1'b1;
        else                  d_ack_d = 1'b1;
      end
      DONE: begin
        last_grant_d = port_q;
      end
      default: ;
    endcase
  end

  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign mem_we      = mem_we_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with a memory model,
// a fixed-priority instance for contention, and the byte-merge unit on its own.
module tb_mem_arbiter;

  logic clk;
  logic reset;

  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_we;

  logic        fp_i_req, fp_d_req, fp_d_we;
  logic [31:0] fp_i_addr, fp_d_addr, fp_d_wdata;
  logic [3:0]  fp_d_be;
  logic [31:0] fp_i_rdata, fp_d_rdata;
  logic        fp_i_ack, fp_d_ack;
  logic [31:0] fp_mem_address, fp_mem_data_in, fp_mem_data_out;
  logic        fp_mem_we;

  logic [31:0] m_old, m_new, m_out;
  logic [3:0]  m_be;

  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_dat;
  int          we_cnt;
  int          base;
  int          n_assert;
  int          n_fail;

  mem_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out)
  );

  mem_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .i_req(fp_i_req), .i_addr(fp_i_addr), .i_rdata(fp_i_rdata), .i_ack(fp_i_ack),
    .d_req(fp_d_req), .d_we(fp_d_we), .d_be(fp_d_be), .d_addr(fp_d_addr),
    .d_wdata(fp_d_wdata), .d_rdata(fp_d_rdata), .d_ack(fp_d_ack),
    .mem_address(fp_mem_address), .mem_data_in(fp_mem_data_in), .mem_we(fp_mem_we),
    .mem_data_out(fp_mem_data_out)
  );

  mem_byte_merge u_mbm (
    .old_word(m_old), .new_word(m_new), .be(m_be), .merged_word(m_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_out    = mem[mem_address[7:2]];
  assign fp_mem_data_out = fp_mem_address ^ 32'h5A5A_0000;

  always @(posedge clk) begin
    if (mem_we)      mem[mem_address[7:2]] <= mem_data_in;
    else if (pre_we) mem[pre_idx] <= pre_dat;
    if (mem_we)      we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
    pre_idx = idx; pre_dat = dat; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic d_issue(input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; we_cnt = 0;
    reset = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_dat = '0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    fp_i_req = 0; fp_i_addr = '0; fp_d_req = 0; fp_d_we = 0; fp_d_be = '0;
    fp_d_addr = '0; fp_d_wdata = '0;
    m_old = '0; m_new = '0; m_be = '0;

    repeat (3) @(negedge clk);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    reset = 1'b0;

    preload(6'd4,  32'hDEADBEEF);
    preload(6'd12, 32'h11223344);
    preload(6'd17, 32'h55667788);
    preload(6'd20, 32'hA5A5A5A5);

    // Single fetch from 0x10
    base = we_cnt;
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    chk("fetch_c1_addr", mem_address, 32'h10);
    chk("fetch_c1_we", mem_we, 0);
    chk("fetch_c1_ack", i_ack, 0);
    @(negedge clk);
    chk("fetch_c2_ack", i_ack, 1);
    chk("fetch_c2_rdata", i_rdata, 32'hDEADBEEF);
    chk("fetch_c2_d_ack", d_ack, 0);
    i_req = 1'b0;
    @(negedge clk);
    chk("fetch_c3_ack", i_ack, 0);
    chk("fetch_we_pulses", we_cnt - base, 0);

    // Full-word store to 0x20, then load it back
    base = we_cnt;
    d_issue(1'b1, 4'b1111, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    chk("fst_c1_we", mem_we, 1);
    chk("fst_c1_data", mem_data_in, 32'hCAFEF00D);
    chk("fst_c1_addr", mem_address, 32'h20);
    chk("fst_c1_ack", d_ack, 0);
    @(negedge clk);
    chk("fst_c2_ack", d_ack, 1);
    chk("fst_c2_we", mem_we, 0);
    chk("fst_c2_addr", mem_address, 32'h20);
    d_issue(1'b0, 4'b0000, 32'h20, 32'h0);
    @(negedge clk);
    chk("fld_c0_ack", d_ack, 0);
    repeat (2) @(negedge clk);
    chk("fld_c2_ack", d_ack, 1);
    chk("fld_c2_rdata", d_rdata, 32'hCAFEF00D);
    chk("fst_we_pulses", we_cnt - base, 1);
    d_req = 1'b0;
    @(negedge clk);

    // Partial store be=0010 to 0x30 over 0x11223344
    base = we_cnt;
    d_issue(1'b1, 4'b0010, 32'h30, 32'h0000AA00);
    @(negedge clk);
    chk("pst_c1_we", mem_we, 0);
    chk("pst_c1_addr", mem_address, 32'h30);
    @(negedge clk);
    chk("pst_c2_we", mem_we, 1);
    chk("pst_c2_data", mem_data_in, 32'h1122AA44);
    chk("pst_c2_ack", d_ack, 0);
    @(negedge clk);
    chk("pst_c3_ack", d_ack, 1);
    chk("pst_c3_we", mem_we, 0);
    chk("pst_c3_addr", mem_address, 32'h30);
    chk("pst_c3_data", mem_data_in, 32'h1122AA44);
    d_issue(1'b0, 4'b0000, 32'h30, 32'h0);
    repeat (3) @(negedge clk);
    chk("pld_ack", d_ack, 1);
    chk("pld_rdata", d_rdata, 32'h1122AA44);
    chk("pst_we_pulses", we_cnt - base, 1);
    d_req = 1'b0;
    @(negedge clk);

    // Store with be=0000 is a no-op that still acks in cycle 2
    base = we_cnt;
    d_issue(1'b1, 4'b0000, 32'h30, 32'hFFFFFFFF);
    @(negedge clk);
    chk("nop_c1_we", mem_we, 0);
    @(negedge clk);
    chk("nop_c2_ack", d_ack, 1);
    d_req = 1'b0;
    @(negedge clk);
    chk("nop_we_pulses", we_cnt - base, 0);
    chk("nop_word", mem[12], 32'h1122AA44);

    // Aliasing guard: store 0x40 then load 0x44
    d_issue(1'b1, 4'b1111, 32'h40, 32'h77777777);
    @(negedge clk);
    chk("alias_c1_addr", mem_address, 32'h40);
    @(negedge clk);
    chk("alias_c2_addr", mem_address, 32'h40);
    chk("alias_c2_we", mem_we, 0);
    chk("alias_c2_ack", d_ack, 1);
    d_issue(1'b0, 4'b0000, 32'h44, 32'h0);
    @(negedge clk);
    chk("alias_idle_addr", mem_address, 32'h40);
    @(negedge clk);
    chk("alias_ld_addr", mem_address, 32'h44);
    @(negedge clk);
    chk("alias_ld_ack", d_ack, 1);
    chk("alias_ld_rdata", d_rdata, 32'h55667788);
    d_req = 1'b0;
    chk("alias_word40", mem[16], 32'h77777777);
    chk("alias_word44", mem[17], 32'h55667788);
    @(negedge clk);

    // Reset during ACCESS of a be=0001 store
    base = we_cnt;
    d_issue(1'b1, 4'b0001, 32'h50, 32'h000000FF);
    @(negedge clk);
    chk("rmw_c1_addr", mem_address, 32'h50);
    chk("rmw_c1_we", mem_we, 0);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rmw_rst_we", mem_we, 0);
    chk("rmw_rst_ack", d_ack, 0);
    chk("rmw_rst_addr", mem_address, 0);
    chk("rmw_rst_data", mem_data_in, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rmw_post_we", mem_we, 0);
    chk("rmw_post_ack", d_ack, 0);
    chk("rmw_we_pulses", we_cnt - base, 0);
    chk("rmw_word", mem[20], 32'hA5A5A5A5);
    i_req = 1'b1; i_addr = 32'h10;
    repeat (2) @(negedge clk);
    chk("rmw_idle_fetch_ack", i_ack, 1);
    i_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Round-robin contention: I, D, I, D
    i_req = 1'b1; i_addr = 32'h10;
    d_issue(1'b0, 4'b0000, 32'h20, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr_i_ack_%0d", k), i_ack, (k % 6) == 2);
      chk($sformatf("rr_d_ack_%0d", k), d_ack, (k % 6) == 5);
      if (k == 2) chk("rr_i_rdata", i_rdata, 32'hDEADBEEF);
      if (k == 5) chk("rr_d_rdata", d_rdata, 32'hCAFEF00D);
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Fixed priority: data wins while requesting, fetch served once it drops
    fp_i_req = 1'b1; fp_i_addr = 32'h10;
    fp_d_req = 1'b1; fp_d_we = 1'b0; fp_d_addr = 32'h20;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("fp_d_ack_%0d", k), fp_d_ack, (k == 2) || (k == 5) || (k == 8));
      chk($sformatf("fp_i_ack_%0d", k), fp_i_ack, k == 11);
      if (k == 2)  chk("fp_d_rdata", fp_d_rdata, 32'h5A5A0020);
      if (k == 11) chk("fp_i_rdata", fp_i_rdata, 32'h5A5A0010);
      if (k == 8)  fp_d_req = 1'b0;
    end
    fp_i_req = 1'b0;

    // Byte-merge unit
    m_old = 32'h11223344; m_new = 32'h0000AA00; m_be = 4'b0010; #1;
    chk("mbm_0010", m_out, 32'h1122AA44);
    m_old = 32'hAABBCCDD; m_new = 32'h11223344; m_be = 4'b0000; #1;
    chk("mbm_0000", m_out, 32'hAABBCCDD);
    m_be = 4'b1111; #1;
    chk("mbm_1111", m_out, 32'h11223344);
    m_be = 4'b1001; #1;
    chk("mbm_1001", m_out, 32'h11BBCC44);
    m_be = 4'b0110; #1;
    chk("mbm_0110", m_out, 32'hAA2233DD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
